// File: rtl/mike_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// mike_pipeline_pkg
//   Constants shared by the pipeline stages of the mike RISC-V core:
//   datapath width, writeback-source selector codes and load funct3 codes.
// -----------------------------------------------------------------------------
package mike_pipeline_pkg;

    // Default datapath width for the core.
    localparam int XLEN = 32;

    // Writeback source selector (wb_sel).
    localparam logic [1:0] WB_ALU  = 2'b00;  // ALU result
    localparam logic [1:0] WB_LOAD = 2'b01;  // extracted load data
    localparam logic [1:0] WB_PC4  = 2'b10;  // link value (JAL/JALR)
    localparam logic [1:0] WB_IMM  = 2'b11;  // U-type immediate (LUI)

    // Load size/sign codes (funct3 of the LOAD opcode).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage : mike_pipeline_pkg

// File: rtl/mike_load_extract.sv
// -----------------------------------------------------------------------------
// mike_load_extract
//   Purely combinational load-data extractor. Picks the addressed byte or
//   halfword out of an aligned memory word, sign- or zero-extends it, and
//   flags illegal funct3 codes and misaligned accesses. The fault output is
//   also used on its own by the store-data aligner.
//
// Ports:
//   funct3  in   3     load size/sign code
//   offset  in   2     byte offset within the word (address[1:0])
//   word    in   XLEN  raw aligned word from data memory
//   value   out  XLEN  extracted, extended load value (0 for illegal funct3)
//   fault   out  1     illegal funct3 or misaligned access
// -----------------------------------------------------------------------------
module mike_load_extract #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] value,
    output logic            fault
);
    import mike_pipeline_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lane chosen by the full offset, halfword lane by offset[1] only;
    // an odd halfword offset is caught by the fault logic below.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first,
        // so no path through the block can leave it unassigned (latch).
        byte_sel = word[7:0];
        case (offset)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        value = '0;
        case (funct3)
            F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   value = word;
            F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
            default: value = '0;
        endcase
    end

    always_comb begin
        fault = 1'b1;
        case (funct3)
            F3_LB, F3_LBU: fault = 1'b0;
            F3_LH, F3_LHU: fault = offset[0];
            F3_LW:         fault = (offset != 2'd0);
            default:       fault = 1'b1;
        endcase
    end

endmodule : mike_load_extract

// File: rtl/mike_writeback_stage.sv
// -----------------------------------------------------------------------------
// mike_writeback_stage
//   MEM/WB pipeline register plus writeback logic. Captures the memory-stage
//   results, extracts load data, selects the final write value and drives the
//   register-file write port. The write is committed by the register file on
//   the same edge the instruction leaves this stage. Also provides a
//   forwarding tap, a retired-instruction counter and a sticky load-fault flag.
//
// Ports:
//   clock             in   1      pipeline clock (shared with register file)
//   reset             in   1      asynchronous, active-high
//   mem_valid         in   1      memory stage holds a valid instruction
//   mem_reg_write     in   1      instruction writes rd
//   mem_rd            in   5      destination register
//   mem_wb_sel        in   2      writeback source (ALU/load/PC+4/imm)
//   mem_funct3        in   3      load size/sign code
//   mem_alu_result    in   XLEN   ALU result, also the load address
//   mem_load_data     in   XLEN   raw aligned word from data memory
//   mem_pc_plus4      in   XLEN   link value
//   mem_imm           in   XLEN   U-type immediate
//   stall             in   1      hold stage contents
//   flush             in   1      invalidate stage contents
//   rf_write_address  out  5      register file write_address
//   rf_write_data     out  XLEN   register file write_data_in
//   rf_write_enable   out  1      register file write_enable
//   fwd_valid         out  1      rf_write_data/address usable for forwarding
//   retire_count      out  RET_W  instructions retired since reset
//   load_fault        out  1      sticky: a faulting load has retired
// -----------------------------------------------------------------------------
module mike_writeback_stage #(
    parameter int XLEN  = mike_pipeline_pkg::XLEN,
    parameter int RET_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_load_data,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [XLEN-1:0]  mem_imm,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       rf_write_address,
    output logic [XLEN-1:0]  rf_write_data,
    output logic             rf_write_enable,
    output logic             fwd_valid,
    output logic [RET_W-1:0] retire_count,
    output logic             load_fault
);
    import mike_pipeline_pkg::*;

    // Stage register fields.
    logic            valid_q;
    logic            reg_write_q;
    logic [4:0]      rd_q;
    logic [1:0]      wb_sel_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] alu_result_q;
    logic [XLEN-1:0] load_data_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic [XLEN-1:0] imm_q;

    // Derived per-cycle status.
    logic [XLEN-1:0] load_value;
    logic            extract_fault;
    logic            fault;
    logic            ret;
    logic            writes_rd;
    logic [XLEN-1:0] wb_value;

    // -------------------------------------------------------------------------
    // Stage register: reset > flush > stall > capture.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the datapath fields are reset too, not just valid_q, so every
        // output (including rf_write_address) reads 0 straight out of reset.
        if (reset) begin
            // NOTE: sequential state is assigned with <= so every flop samples
            // the pre-edge values regardless of statement order.
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            wb_sel_q     <= WB_ALU;
            funct3_q     <= '0;
            alu_result_q <= '0;
            load_data_q  <= '0;
            pc_plus4_q   <= '0;
            imm_q        <= '0;
        end else if (flush) begin
            // Only valid matters once the slot is invalidated.
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q      <= mem_valid;
            reg_write_q  <= mem_reg_write;
            rd_q         <= mem_rd;
            wb_sel_q     <= mem_wb_sel;
            funct3_q     <= mem_funct3;
            alu_result_q <= mem_alu_result;
            load_data_q  <= mem_load_data;
            pc_plus4_q   <= mem_pc_plus4;
            imm_q        <= mem_imm;
        end
    end

    // -------------------------------------------------------------------------
    // Load extraction and fault detection.
    // -------------------------------------------------------------------------
    mike_load_extract #(
        .XLEN (XLEN)
    ) u_load_extract (
        .funct3 (funct3_q),
        .offset (alu_result_q[1:0]),
        .word   (load_data_q),
        .value  (load_value),
        .fault  (extract_fault)
    );

    // Only loads can fault; funct3 of other instructions is meaningless here.
    assign fault = (wb_sel_q == WB_LOAD) && extract_fault;

    // The instruction leaves the stage on the coming edge unless stalled.
    // A flush without stall still lets the outgoing instruction retire,
    // because this is evaluated from the current contents before the edge.
    assign ret = valid_q && !stall;

    // A live, non-faulting write to a real register (x0 is never written).
    assign writes_rd = valid_q && reg_write_q && (rd_q != 5'd0) && !fault;

    // -------------------------------------------------------------------------
    // Writeback value selection.
    // -------------------------------------------------------------------------
    always_comb begin
        wb_value = alu_result_q;
        case (wb_sel_q)
            WB_ALU:  wb_value = alu_result_q;
            WB_LOAD: wb_value = load_value;
            WB_PC4:  wb_value = pc_plus4_q;
            WB_IMM:  wb_value = imm_q;
            default: wb_value = alu_result_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Register-file port and forwarding tap.
    // -------------------------------------------------------------------------
    assign rf_write_address = rd_q;
    assign rf_write_data    = valid_q ? wb_value : '0;
    assign rf_write_enable  = ret && writes_rd;
    // Held high through a stall so younger instructions can keep forwarding.
    assign fwd_valid        = writes_rd;

    // -------------------------------------------------------------------------
    // Retire counter and sticky load-fault flag.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
            load_fault   <= 1'b0;
        end else begin
            // Faulted instructions still retire; the counter wraps naturally.
            if (ret) begin
                retire_count <= retire_count + RET_W'(1);
            end
            if (ret && fault) begin
                load_fault <= 1'b1;
            end
        end
    end

endmodule : mike_writeback_stage

// File: tb/tb_mike_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_mike_writeback_stage
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural model of the writeback stage kept in this bench.
// -----------------------------------------------------------------------------
module tb_mike_writeback_stage;

    localparam int XLEN  = 32;
    localparam int RET_W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             mem_valid;
    logic             mem_reg_write;
    logic [4:0]       mem_rd;
    logic [1:0]       mem_wb_sel;
    logic [2:0]       mem_funct3;
    logic [XLEN-1:0]  mem_alu_result;
    logic [XLEN-1:0]  mem_load_data;
    logic [XLEN-1:0]  mem_pc_plus4;
    logic [XLEN-1:0]  mem_imm;
    logic             stall;
    logic             flush;
    logic [4:0]       rf_write_address;
    logic [XLEN-1:0]  rf_write_data;
    logic             rf_write_enable;
    logic             fwd_valid;
    logic [RET_W-1:0] retire_count;
    logic             load_fault;

    always #5 clock = ~clock;

    mike_writeback_stage #(
        .XLEN  (XLEN),
        .RET_W (RET_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .mem_valid        (mem_valid),
        .mem_reg_write    (mem_reg_write),
        .mem_rd           (mem_rd),
        .mem_wb_sel       (mem_wb_sel),
        .mem_funct3       (mem_funct3),
        .mem_alu_result   (mem_alu_result),
        .mem_load_data    (mem_load_data),
        .mem_pc_plus4     (mem_pc_plus4),
        .mem_imm          (mem_imm),
        .stall            (stall),
        .flush            (flush),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .rf_write_enable  (rf_write_enable),
        .fwd_valid        (fwd_valid),
        .retire_count     (retire_count),
        .load_fault       (load_fault)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: the instruction sitting in the stage, plus counters.
    // ---------------------------------------------------------------------
    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_ld, m_pc4, m_imm;
    logic [31:0] m_count;
    logic        m_fault;

    // Access size in bytes for a load funct3, 0 when the code is illegal.
    function automatic int load_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit load_bad(input logic [2:0] f3, input logic [1:0] off);
        int size = load_size(f3);
        if (size == 0) return 1'b1;
        return (int'(off) % size) != 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        int          size = load_size(f3);
        logic [31:0] mask;
        logic [31:0] v;
        if (size == 4) return word;
        if (size == 0) return 32'h0;
        mask = (32'd1 << (8 * size)) - 32'd1;
        v    = (word >> (8 * int'(off))) & mask;
        // Signed variants are the codes below 4.
        if (f3 < 3'd4 && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit model_fault();
        return (m_wb == 2'd1) && load_bad(m_f3, m_alu[1:0]);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_wb = 0; m_f3 = 0;
        m_alu = 0; m_ld = 0; m_pc4 = 0; m_imm = 0;
        m_count = 0; m_fault = 0;
    endtask

    // Applied at each rising edge with the inputs present at that edge.
    task automatic model_update();
        bit leaving = m_valid && !stall;
        if (leaving) m_count = m_count + 1;
        if (leaving && model_fault()) m_fault = 1'b1;
        if (flush) begin
            m_valid = 1'b0;
        end else if (!stall) begin
            m_valid = mem_valid;   m_rw  = mem_reg_write; m_rd  = mem_rd;
            m_wb    = mem_wb_sel;  m_f3  = mem_funct3;    m_alu = mem_alu_result;
            m_ld    = mem_load_data; m_pc4 = mem_pc_plus4; m_imm = mem_imm;
        end
    endtask

    task automatic compare();
        bit          flt  = model_fault();
        bit          live = m_valid && m_rw && (m_rd != 5'd0) && !flt;
        logic [31:0] d;
        case (m_wb)
            2'd0:    d = m_alu;
            2'd1:    d = load_value(m_f3, m_alu[1:0], m_ld);
            2'd2:    d = m_pc4;
            default: d = m_imm;
        endcase
        check("write_enable", rf_write_enable, live && !stall);
        check("fwd_valid", fwd_valid, live);
        check("retire_count", retire_count, m_count);
        check("load_fault", load_fault, m_fault);
        if (!m_valid) check("data_idle", rf_write_data, 32'h0);
        else if (!flt) check("write_data", rf_write_data, d);
        if (m_valid) check("write_address", rf_write_address, m_rd);
    endtask

    // One clock: compare on the falling edge, advance the model on the rising
    // edge, return just after it so new inputs can be driven.
    task automatic cycle();
        @(negedge clock);
        compare();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] wb,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4, input logic [31:0] imm);
        mem_valid = 1'b1; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = wb;
        mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld;
        mem_pc_plus4 = pc4; mem_imm = imm;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
    endtask

    // Issue one instruction, let it settle into the stage, then check the
    // write port before it retires.
    task automatic one_shot(input string tag, input logic [1:0] wb, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] ld,
                            input logic [31:0] exp_data, input logic exp_we);
        issue(1'b1, 5'd10, wb, f3, alu, ld, 32'h0, 32'h0);
        cycle();
        idle();
        #1;
        check({tag, "_we"}, rf_write_enable, exp_we);
        if (exp_we) check({tag, "_data"}, rf_write_data, exp_data);
        cycle();
    endtask

    logic [31:0] count_before;

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_valid = 0; mem_reg_write = 0; mem_rd = 0; mem_wb_sel = 0; mem_funct3 = 0;
        mem_alu_result = 0; mem_load_data = 0; mem_pc_plus4 = 0; mem_imm = 0;
        model_reset();
        #1;
        check("rst_we", rf_write_enable, 1'b0);
        check("rst_fwd", fwd_valid, 1'b0);
        check("rst_data", rf_write_data, 32'h0);
        check("rst_addr", rf_write_address, 5'd0);
        check("rst_count", retire_count, 32'd0);
        check("rst_fault", load_fault, 1'b0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;

        // ALU writeback.
        issue(1'b1, 5'd5, 2'b00, 3'd0, 32'h1234, 32'h0, 32'h0, 32'h0);
        cycle();
        idle();
        #1;
        check("alu_we", rf_write_enable, 1'b1);
        check("alu_addr", rf_write_address, 5'd5);
        check("alu_data", rf_write_data, 32'h1234);
        cycle();
        check("alu_count", retire_count, 32'd1);

        // Sign / zero extension.
        one_shot("lb", 2'b01, 3'd0, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80, 1'b1);
        one_shot("lbu", 2'b01, 3'd4, 32'h103, 32'h80FF_0000, 32'h0000_0080, 1'b1);
        one_shot("lhu", 2'b01, 3'd5, 32'h102, 32'hBEEF_0000, 32'h0000_BEEF, 1'b1);
        one_shot("lh", 2'b01, 3'd1, 32'h102, 32'hBEEF_0000, 32'hFFFF_BEEF, 1'b1);
        check("ext_count", retire_count, 32'd5);

        // Misaligned word load.
        one_shot("lw_mis", 2'b01, 3'd2, 32'h102, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check("mis_fault", load_fault, 1'b1);
        check("mis_count", retire_count, 32'd6);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("fault_sticky", load_fault, 1'b1);
        end

        // Stall holds a valid write for three cycles.
        issue(1'b1, 5'd7, 2'b00, 3'd0, 32'hCAFE, 32'h0, 32'h0, 32'h0);
        cycle();
        idle();
        stall = 1'b1;
        count_before = m_count;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_we", rf_write_enable, 1'b0);
            check("stall_fwd", fwd_valid, 1'b1);
            cycle();
        end
        stall = 1'b0;
        #1;
        check("release_we", rf_write_enable, 1'b1);
        check("release_addr", rf_write_address, 5'd7);
        cycle();
        check("release_count", retire_count, count_before + 32'd1);
        check("release_once", rf_write_enable, 1'b0);

        // Write to x0 retires without enabling the register file.
        issue(1'b1, 5'd0, 2'b00, 3'd0, 32'h55, 32'h0, 32'h0, 32'h0);
        cycle();
        idle();
        #1;
        check("x0_we", rf_write_enable, 1'b0);
        count_before = m_count;
        cycle();
        check("x0_count", retire_count, count_before + 32'd1);

        // Flush together with stall drops the instruction.
        issue(1'b1, 5'd9, 2'b00, 3'd0, 32'h99, 32'h0, 32'h0, 32'h0);
        cycle();
        idle();
        stall = 1'b1; flush = 1'b1;
        count_before = m_count;
        #1;
        check("fs_we", rf_write_enable, 1'b0);
        cycle();
        stall = 1'b0; flush = 1'b0;
        #1;
        check("fs_fwd", fwd_valid, 1'b0);
        check("fs_data", rf_write_data, 32'h0);
        check("fs_count", retire_count, count_before);
        cycle();

        // Asynchronous reset in the middle of a stall.
        issue(1'b1, 5'd3, 2'b00, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0);
        cycle();
        idle();
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_we", rf_write_enable, 1'b0);
        check("arst_fwd", fwd_valid, 1'b0);
        check("arst_data", rf_write_data, 32'h0);
        check("arst_addr", rf_write_address, 5'd0);
        check("arst_count", retire_count, 32'd0);
        check("arst_fault", load_fault, 1'b0);
        model_reset();
        @(negedge clock);
        reset = 1'b0; stall = 1'b0;
        issue(1'b1, 5'd1, 2'b10, 3'd0, 32'h0, 32'h0, 32'h48, 32'h0);
        @(posedge clock);
        model_update();
        #1;
        idle();
        #1;
        check("jal_we", rf_write_enable, 1'b1);
        check("jal_data", rf_write_data, 32'h48);
        cycle();
        check("jal_count", retire_count, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            mem_valid      = ($urandom_range(3, 0) != 0);
            mem_reg_write  = ($urandom_range(4, 0) != 0);
            mem_rd         = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            mem_wb_sel     = 2'($urandom_range(3, 0));
            mem_funct3     = 3'($urandom_range(7, 0));
            mem_alu_result = $urandom;
            if ($urandom_range(1, 0) == 0) mem_alu_result[1:0] = 2'b00;
            mem_load_data  = $urandom;
            mem_pc_plus4   = $urandom;
            mem_imm        = $urandom;
            stall          = ($urandom_range(3, 0) == 0);
            flush          = ($urandom_range(7, 0) == 0);
            cycle();
        end
        stall = 1'b0; flush = 1'b0; idle();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mike_writeback_stage
